// File: rtl/cla_chunk_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cla_chunk_sequencer
//  Description : Multi-cycle WIDTH-bit add/subtract controller that time-shares
//                one external combinational CHUNK-bit CLA slice, LSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_chunk_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [CHUNK-1:0] cla_a,
    output logic [CHUNK-1:0] cla_b,
    output logic             cla_cin,
    input  logic [CHUNK-1:0] cla_s,
    input  logic             cla_cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NCHUNK - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic             w_run;
    int               w_base;

    assign w_run = (r_state == C_RUN);

    // Bit offset of the chunk currently on the slice
    always_comb begin
        w_base = int'(r_idx) * CHUNK;
    end

    // Slice inputs are parked at zero whenever the sequencer is not stepping
    always_comb begin
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;
        if (w_run) begin
            cla_a   = r_a[w_base +: CHUNK];
            cla_b   = r_b[w_base +: CHUNK];
            cla_cin = r_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B now, inject the +1 as carry-in
                        r_a     <= in_a;
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_carry <= in_sub;
                        r_sum   <= '0;
                        r_idx   <= '0;
                        r_state <= C_RUN;
                    end
                end
                C_RUN: begin
                    r_sum[w_base +: CHUNK] <= cla_s;
                    r_carry                <= cla_cout;
                    r_idx                  <= r_idx + 1'b1;
                    if (r_idx == C_LAST_IDX) begin
                        r_state <= C_DONE;
                    end
                end
                C_DONE: begin
                    if (out_ready) begin
                        r_state <= C_IDLE;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == C_IDLE);
    assign out_valid = (r_state == C_DONE);
    assign busy      = (r_state == C_RUN) || (r_state == C_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_carry;
    // Overflow uses the post-inversion B so one rule covers add and subtract
    assign out_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_sum[WIDTH-1] != r_a[WIDTH-1]);

endmodule
`default_nettype wire

// File: tb/tb_cla_chunk_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_chunk_sequencer
//  Description : Directed self-checking bench with a behavioural 8-bit slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_chunk_sequencer;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic [CHUNK-1:0] cla_a;
    logic [CHUNK-1:0] cla_b;
    logic             cla_cin;
    logic [CHUNK-1:0] cla_s;
    logic             cla_cout;
    logic             busy;

    logic [CHUNK:0]   slice;
    assign slice    = {1'b0, cla_a} + {1'b0, cla_b} + {{CHUNK{1'b0}}, cla_cin};
    assign cla_s    = slice[CHUNK-1:0];
    assign cla_cout = slice[CHUNK];

    cla_chunk_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .cla_a     (cla_a),
        .cla_b     (cla_b),
        .cla_cin   (cla_cin),
        .cla_s     (cla_s),
        .cla_cout  (cla_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {ovf, cout, sum} of a reference two's-complement add/subtract
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic sub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   r;
        logic             ovf;
        bb  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
        ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return {ovf, r};
    endfunction

    task automatic start_op(input string tag, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic sub);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        check({tag, "_ready_pre"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check({tag, "_busy_run"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_result(output int lat, output logic cin2);
        lat  = 0;
        cin2 = 1'b0;
        while (!out_valid && lat < 20) begin
            if (lat == 1) cin2 = cla_cin;
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] es,
                                input logic ec, input logic eo);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"},   64'(out_sum),   64'(es));
        check({tag, "_cout"},  64'(out_cout),  64'(ec));
        check({tag, "_ovf"},   64'(out_ovf),   64'(eo));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_post"}, 64'(in_ready),  64'd1);
        check({tag, "_busy_post"},  64'(busy),      64'd0);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic sub,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int   lat;
        logic cin2;
        start_op(tag, a, b, sub);
        wait_result(lat, cin2);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check_result(tag, es, ec, eo);
        handshake(tag);
    endtask

    initial begin
        int                 lat;
        logic               cin2;
        int                 n;
        int                 acc [3];
        logic [WIDTH-1:0]   ra, rb;
        logic               rs;
        logic [WIDTH+1:0]   exp_r;

        // Reset state, sampled while rst_n is still low
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum",       64'(out_sum),   64'd0);
        check("rst_cout",      64'(out_cout),  64'd0);
        check("rst_ovf",       64'(out_ovf),   64'd0);
        check("rst_cla",       64'({cla_a, cla_b, cla_cin}), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // Carry ripples out of chunk 0 into the 2nd RUN cycle
        start_op("add_ff", 32'h0000_00FF, 32'h0000_0001, 1'b0);
        check("add_ff_cla_a0", 64'(cla_a), 64'hFF);
        wait_result(lat, cin2);
        check("add_ff_latency", 64'(lat), 64'd4);
        check("add_ff_cin2", 64'(cin2), 64'd1);
        check_result("add_ff", 32'h0000_0100, 1'b0, 1'b0);
        handshake("add_ff");
        check("idle_cla_zero", 64'({cla_a, cla_b, cla_cin}), 64'd0);

        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure with stray in_valid pulses while holding DONE
        start_op("bp", 32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_result(lat, cin2);
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 32'hDEAD_0000 + 32'(i);
            in_b     = 32'h0000_BEEF;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_sum",   64'(out_sum),   64'h2345_6789);
            check("bp_hold_ready", 64'(in_ready),  64'd0);
            step();
        end
        in_valid = 1'b0;
        check_result("bp", 32'h2345_6789, 1'b0, 1'b0);
        handshake("bp");
        step();
        check("bp_no_queue", 64'(busy), 64'd0);

        // Asynchronous abort in the 2nd RUN cycle
        start_op("abort", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        step();
        check("abort_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy",  64'(busy),      64'd0);
        check("abort_cla",   64'({cla_a, cla_b, cla_cin}), 64'd0);
        check("abort_sum",   64'(out_sum),   64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("abort_in_ready", 64'(in_ready), 64'd1);
        run_op("post_abort", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

        // Back-to-back: accept, four RUN cycles, one DONE cycle, one IDLE cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ra    = $urandom;
            rb    = $urandom;
            rs    = 1'($urandom_range(0, 1));
            exp_r = model(ra, rb, rs);
            in_a   = ra;
            in_b   = rb;
            in_sub = rs;
            n = 0;
            while (!in_ready && n < 20) begin
                step();
                n++;
            end
            check("b2b_ready", 64'(in_ready), 64'd1);
            acc[k] = cycle;
            if (k > 0) check("b2b_spacing", 64'(acc[k] - acc[k-1]), 64'd6);
            step();
            if (k == 2) in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin
                step();
                n++;
            end
            check("b2b_latency", 64'(n), 64'd4);
            check_result("b2b", exp_r[WIDTH-1:0], exp_r[WIDTH], exp_r[WIDTH+1]);
        end
        step();
        out_ready = 1'b0;
        check("b2b_end_ready", 64'(in_ready), 64'd1);
        check("b2b_end_busy",  64'(busy),     64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
